// File: rtl/access_ctrl_wb.sv
// Data-side access controller: posted write buffer with forwarding,
// read-miss handling, LL/SC link tracking and halt-time flush.
module access_ctrl_wb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WB_DEPTH  = 4,
  parameter int ATOMIC_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  input  logic              halt,
  input  logic              hit,
  input  logic [DATA_W-1:0] ddata,
  input  logic              dwait,
  input  logic [DATA_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dstore,
  output logic              wempty,
  output logic              flushed
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, FLUSH, HALTED} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PW-1:0]     head, tail, idx;
  logic [CW-1:0]     count;
  logic              link_v;
  logic [ADDR_W-1:0] link_a;

  logic wr, rd, is_ll, is_sc, snoop_req, sc_ok;
  logic full, drain, enq, pop, fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

  assign wr        = dmemWEN;
  assign rd        = dmemREN && !dmemWEN;
  assign is_ll     = (ATOMIC_EN != 0) && datomic && rd;
  assign is_sc     = (ATOMIC_EN != 0) && datomic && wr;
  assign snoop_req = snoop_inv && same_word(snoop_addr, dmemaddr);
  assign sc_ok     = link_v && same_word(link_a, dmemaddr) && !snoop_req;
  assign full      = count == CW'(WB_DEPTH);
  assign drain     = (state == IDLE || state == FLUSH) && count != '0;
  assign wempty    = (count == '0) && !dWEN;
  assign flushed   = state == HALTED;

  // Walk oldest to youngest so the last match is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && same_word(wb_addr[idx], dmemaddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
    end
  end

  always_comb begin
    state_n  = state;
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    enq      = 1'b0;
    pop      = 1'b0;
    if (drain) begin
      dWEN   = 1'b1;
      daddr  = wb_addr[head];
      dstore = wb_data[head];
      pop    = !dwait;
    end
    unique case (state)
      IDLE: begin
        if (halt) begin
          state_n = FLUSH;
        end else if (wr) begin
          if (is_sc && !sc_ok) begin
            dhit = 1'b1;
          end else if (!full) begin
            enq      = 1'b1;
            dhit     = 1'b1;
            dmemload = is_sc ? DATA_W'(1) : '0;
          end
        end else if (rd) begin
          if (fwd_hit) begin
            dhit     = 1'b1;
            dmemload = fwd_data;
          end else if (hit) begin
            dhit     = 1'b1;
            dmemload = ddata;
          end else if (!(drain && dwait)) begin
            state_n = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        dREN  = 1'b1;
        daddr = dmemaddr;
        if (!dwait) begin
          dhit     = 1'b1;
          dmemload = dload;
          state_n  = IDLE;
        end
      end
      FLUSH: begin
        if (count == '0) state_n = HALTED;
      end
      HALTED: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      wb_addr[tail] <= dmemaddr;
      wb_data[tail] <= dmemstore;
    end
  end

  // A snoop on the very address being linked leaves the link invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_v <= 1'b0;
      link_a <= '0;
    end else if (halt || ATOMIC_EN == 0) begin
      link_v <= 1'b0;
    end else if (is_ll && dhit) begin
      link_v <= !snoop_req;
      link_a <= dmemaddr;
    end else if ((snoop_inv && same_word(snoop_addr, link_a)) ||
                 (enq && same_word(dmemaddr, link_a))) begin
      link_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_access_ctrl_wb.sv
// Bench for access_ctrl_wb: directed scenarios plus a randomized
// program checked against an architectural memory model.
module tb_access_ctrl_wb;

  logic        CLK = 1'b0;
  logic        RST, dmemREN, dmemWEN, datomic, halt, hit, dwait, snoop_inv;
  logic [31:0] dmemaddr, dmemstore, ddata, dload, snoop_addr;
  logic        dhit, dREN, dWEN, wempty, flushed;
  logic [31:0] dmemload, daddr, dstore;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [63:0] wlog [$];
  logic [31:0] ref_mem [8];

  access_ctrl_wb dut (
    .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .hit(hit), .ddata(ddata), .dwait(dwait),
    .dload(dload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dhit(dhit), .dmemload(dmemload), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .wempty(wempty),
    .flushed(flushed)
  );

  always #5 CLK = ~CLK;

  always_comb dload = mem[daddr[9:2]];

  always @(posedge CLK) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (dWEN && !dwait) begin
      mem[daddr[9:2]] <= dstore;
      wlog.push_back({daddr, dstore});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0; hit = 0;
    dmemaddr = 0; dmemstore = 0; ddata = 0; snoop_inv = 0;
    snoop_addr = 0;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    pre_en = 1; pre_idx = a[9:2]; pre_val = v;
    tick();
    pre_en = 0;
  endtask

  task automatic wait_empty(input string name);
    dwait = 0;
    for (int c = 0; c < 30 && !wempty; c++) tick();
    checks++;
    if (wempty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: wempty=%b required 1", name, wempty);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    dwait = 0;
    RST = 1;
    tick(); tick();
    RST = 0;
    settle();
    checks++;
    if ({dhit, dREN, dWEN, wempty, flushed} !== 5'b00010 ||
        dmemload !== 0 || daddr !== 0 || dstore !== 0) begin
      errors++;
      $display("FAIL reset: dhit/dREN/dWEN/wempty/flushed=%b%b%b%b%b load=%h addr=%h st=%h required 00010 0 0 0",
               dhit, dREN, dWEN, wempty, flushed, dmemload, daddr, dstore);
    end
    tick();
  endtask

  task automatic test_store_buffer();
    logic [31:0] d [5];
    logic [63:0] e;
    wlog.delete();
    dwait = 1;
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      dmemWEN = 1; dmemaddr = 32'h100 + 32'(k * 4); dmemstore = d[k];
      settle();
      checks++;
      if (dhit !== 1'b1) begin
        errors++;
        $display("FAIL sw_accept%0d: dhit=%b required 1", k, dhit);
      end
      tick();
    end
    d[4] = $urandom;
    dmemaddr = 32'h110; dmemstore = d[4];
    settle();
    checks++;
    if (dhit !== 1'b0 || dWEN !== 1'b1 || daddr !== 32'h100) begin
      errors++;
      $display("FAIL sw_full: dhit=%b dWEN=%b daddr=%h required 0 1 100",
               dhit, dWEN, daddr);
    end
    tick();
    dwait = 0;
    settle();
    checks++;
    if (dhit !== 1'b0) begin
      errors++;
      $display("FAIL sw_pop_cycle: dhit=%b required 0", dhit);
    end
    tick();
    settle();
    checks++;
    if (dhit !== 1'b1) begin
      errors++;
      $display("FAIL sw_after_pop: dhit=%b required 1", dhit);
    end
    tick();
    dmemWEN = 0;
    wait_empty("sw");
    checks++;
    if (wlog.size() != 5) begin
      errors++;
      $display("FAIL sw_count: writes=%0d required 5", wlog.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        e = {32'h100 + 32'(k * 4), d[k]};
        checks++;
        if (wlog[k] !== e) begin
          errors++;
          $display("FAIL sw_order%0d: got %h required %h", k, wlog[k], e);
        end
      end
    end
  endtask

  task automatic test_forward();
    dwait = 1;
    dmemWEN = 1; dmemaddr = 32'h200; dmemstore = 32'hDEAD;
    settle();
    tick();
    dmemWEN = 0; dmemREN = 1; hit = 0;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'hDEAD || dREN !== 1'b0) begin
      errors++;
      $display("FAIL forward: dhit=%b load=%h dREN=%b required 1 DEAD 0",
               dhit, dmemload, dREN);
    end
    tick();
    dmemREN = 0;
    settle();
    checks++;
    if (dREN !== 1'b0) begin
      errors++;
      $display("FAIL forward_nomiss: dREN=%b required 0", dREN);
    end
    wait_empty("fwd");
  endtask

  task automatic test_read_miss();
    poke(32'h300, 32'h1234);
    dwait = 1;
    dmemREN = 1; dmemaddr = 32'h300; hit = 0;
    settle();
    checks++;
    if (dhit !== 1'b0 || dREN !== 1'b0) begin
      errors++;
      $display("FAIL miss_c0: dhit=%b dREN=%b required 0 0", dhit, dREN);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      settle();
      checks++;
      if (dhit !== 1'b0 || dREN !== 1'b1 || daddr !== 32'h300) begin
        errors++;
        $display("FAIL miss_wait%0d: dhit=%b dREN=%b daddr=%h required 0 1 300",
                 c, dhit, dREN, daddr);
      end
    end
    tick();
    dwait = 0;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'h1234) begin
      errors++;
      $display("FAIL miss_done: dhit=%b load=%h required 1 1234",
               dhit, dmemload);
    end
    tick();
    dmemREN = 0;
  endtask

  task automatic test_llsc();
    int n;
    dwait = 1;
    wlog.delete();
    dmemREN = 1; datomic = 1; dmemaddr = 32'h400; hit = 1; ddata = 32'h55;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'h55) begin
      errors++;
      $display("FAIL ll: dhit=%b load=%h required 1 55", dhit, dmemload);
    end
    tick();
    dmemREN = 0; dmemWEN = 1; dmemstore = 7;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'd1) begin
      errors++;
      $display("FAIL sc_ok: dhit=%b load=%h required 1 1", dhit, dmemload);
    end
    tick();
    dmemWEN = 0; datomic = 0;
    wait_empty("sc");
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {32'h400, 32'd7}) begin
      errors++;
      $display("FAIL sc_store: writes=%0d first=%h required 1 0000040000000007",
               wlog.size(), wlog.size() > 0 ? wlog[0] : 64'h0);
    end
    datomic = 1; dmemWEN = 1; dmemstore = 8;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'd0) begin
      errors++;
      $display("FAIL sc_nolink: dhit=%b load=%h required 1 0", dhit, dmemload);
    end
    tick();
    dmemWEN = 0; dmemREN = 1;
    settle();
    tick();
    dmemREN = 0; dmemWEN = 1; dmemstore = 9;
    snoop_inv = 1; snoop_addr = 32'h400;
    settle();
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'd0) begin
      errors++;
      $display("FAIL sc_snoop: dhit=%b load=%h required 1 0", dhit, dmemload);
    end
    tick();
    idle_inputs();
    n = wlog.size();
    tick();
    checks++;
    if (wempty !== 1'b1 || wlog.size() != n) begin
      errors++;
      $display("FAIL sc_fail_noenq: wempty=%b writes=%0d required 1 %0d",
               wempty, wlog.size(), n);
    end
  endtask

  task automatic do_req(input logic w, input logic at,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic sn, output logic [31:0] res,
                        output logic ok);
    ok = 0; res = 0;
    dmemWEN = w; dmemREN = !w; datomic = at;
    dmemaddr = a; dmemstore = d;
    snoop_inv = sn; snoop_addr = a;
    for (int c = 0; c < 80 && !ok; c++) begin
      dwait = ($urandom_range(0, 2) == 0);
      hit = $urandom_range(0, 1) == 1;
      ddata = mem[a[9:2]];
      settle();
      checks++;
      if (dREN && dWEN) begin
        errors++;
        $display("FAIL strobes: dREN=%b dWEN=%b required not both", dREN, dWEN);
      end
      if (dhit) begin
        ok = 1;
        res = dmemload;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] a, d, res;
    logic ok, sn;
    int op, i;
    for (int k = 0; k < 8; k++) begin
      ref_mem[k] = $urandom;
      poke(32'h800 + 32'(k * 4), ref_mem[k]);
    end
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      i = int'($urandom_range(0, 7));
      a = 32'h800 + 32'(i * 4);
      d = $urandom;
      if (op < 4) begin
        do_req(1, 0, a, d, 0, res, ok);
        if (ok) ref_mem[i] = d;
      end else if (op < 8) begin
        do_req(0, 0, a, 0, 0, res, ok);
        checks++;
        if (ok && res !== ref_mem[i]) begin
          errors++;
          $display("FAIL rnd_load%0d: addr=%h got %h required %h",
                   n, a, res, ref_mem[i]);
        end
      end else begin
        do_req(0, 1, a, 0, 0, res, ok);
        checks++;
        if (ok && res !== ref_mem[i]) begin
          errors++;
          $display("FAIL rnd_ll%0d: addr=%h got %h required %h",
                   n, a, res, ref_mem[i]);
        end
        sn = $urandom_range(0, 1) == 1;
        do_req(1, 1, a, d, sn, res, ok);
        checks++;
        if (ok && res !== (sn ? 32'd0 : 32'd1)) begin
          errors++;
          $display("FAIL rnd_sc%0d: got %h required %h", n, res,
                   sn ? 32'd0 : 32'd1);
        end
        if (ok && !sn) ref_mem[i] = d;
      end
      if (!ok) begin
        errors++;
        $display("FAIL rnd_timeout%0d: no dhit within bound", n);
      end
    end
    wait_empty("rnd");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[8'(k)] !== ref_mem[k]) begin
        errors++;
        $display("FAIL rnd_mem%0d: got %h required %h", k, mem[8'(k)], ref_mem[k]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    wlog.delete();
    dwait = 1;
    dmemWEN = 1; dmemaddr = 32'h500; dmemstore = d0;
    settle(); tick();
    dmemaddr = 32'h504; dmemstore = d1;
    settle(); tick();
    dmemWEN = 0;
    halt = 1; dmemREN = 1; dmemaddr = 32'h508; hit = 1; ddata = 9;
    settle();
    checks++;
    if (dhit !== 1'b0) begin
      errors++;
      $display("FAIL halt_nohit: dhit=%b required 0", dhit);
    end
    tick();
    settle();
    checks++;
    if (dhit !== 1'b0 || flushed !== 1'b0) begin
      errors++;
      $display("FAIL flushing: dhit=%b flushed=%b required 0 0", dhit, flushed);
    end
    dwait = 0;
    for (int c = 0; c < 20 && !flushed; c++) tick();
    settle();
    checks++;
    if (flushed !== 1'b1 || dhit !== 1'b0) begin
      errors++;
      $display("FAIL flushed: flushed=%b dhit=%b required 1 0", flushed, dhit);
    end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== {32'h500, d0} ||
        wlog[1] !== {32'h504, d1}) begin
      errors++;
      $display("FAIL flush_writes: count=%0d required 2 in order", wlog.size());
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid();
    idle_inputs();
    RST = 1; tick(); RST = 0;
    dwait = 1;
    for (int k = 0; k < 3; k++) begin
      dmemWEN = 1; dmemaddr = 32'h600 + 32'(k * 4); dmemstore = $urandom;
      settle(); tick();
    end
    dmemWEN = 0;
    settle();
    checks++;
    if (dWEN !== 1'b1 || wempty !== 1'b0) begin
      errors++;
      $display("FAIL pre_rst: dWEN=%b wempty=%b required 1 0", dWEN, wempty);
    end
    RST = 1;
    tick();
    settle();
    checks++;
    if (dWEN !== 1'b0 || wempty !== 1'b1 || flushed !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: dWEN=%b wempty=%b flushed=%b required 0 1 0",
               dWEN, wempty, flushed);
    end
    RST = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    dwait = 0;
    test_reset();
    test_store_buffer();
    test_forward();
    test_read_miss();
    test_llsc();
    test_random();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
